// File: rtl/seg_scan.sv
// seg_scan: time-multiplexed seven-segment scan controller with frame-boundary data commit
//
// Ports:
//   clk         rising-edge clock
//   rst_n       asynchronous active-low reset
//   en          scan enable; low holds the controller idle with the display dark
//   update      one-cycle strobe that stages data/dp_in
//   data        4*DIGITS nibbles, digit 0 in the least significant nibble
//   dp_in       decimal point per digit
//   digit_en    live per-digit mask; a zero keeps that digit dark during its slot
//   hex         nibble of the current slot (to the segment decoder)
//   dp_out      decimal point of the current slot
//   an          one-hot active-high digit select, or all zero
//   frame_start one-cycle pulse on the first cycle of slot 0
//   busy        staged data waiting for the next frame boundary
module seg_scan #(
  parameter int DIGITS   = 4,
  parameter int SCAN_DIV = 1000,
  parameter int BLANK    = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  en,
  input  logic                  update,
  input  logic [4*DIGITS-1:0]   data,
  input  logic [DIGITS-1:0]     dp_in,
  input  logic [DIGITS-1:0]     digit_en,
  output logic [3:0]            hex,
  output logic                  dp_out,
  output logic [DIGITS-1:0]     an,
  output logic                  frame_start,
  output logic                  busy
);
  localparam int CW = $clog2(SCAN_DIV);
  localparam int IW = $clog2(DIGITS);
  localparam logic [CW-1:0] CNT_LAST = CW'(SCAN_DIV - 1);
  localparam logic [IW-1:0] IDX_LAST = IW'(DIGITS - 1);
  typedef enum logic [1:0] {S_IDLE, S_BLANK, S_ON} state_t;
  state_t state, state_n;
  logic [CW-1:0] cnt, cnt_n;
  logic [IW-1:0] idx, idx_n;
  logic [4*DIGITS-1:0] staged_data, staged_data_n, shadow_data, shadow_data_n;
  logic [DIGITS-1:0] staged_dp, staged_dp_n, shadow_dp, shadow_dp_n;
  logic pending, pending_n, commit;
  logic [3:0] hex_n;
  logic dp_n;
  logic [DIGITS-1:0] an_n;
  // Next-state logic. Outputs are computed from the next state so that the
  // registered outputs describe the slot/state being entered on each edge.
  always_comb begin
    cnt_n  = cnt;
    idx_n  = idx;
    commit = 1'b0;
    if (!en) begin
      cnt_n = '0;
      idx_n = '0;
    end else if (state == S_IDLE) begin
      cnt_n  = '0;
      idx_n  = '0;
      commit = 1'b1;
    end else if (cnt == CNT_LAST) begin
      cnt_n  = '0;
      idx_n  = (idx == IDX_LAST) ? '0 : idx + 1'b1;
      commit = (idx == IDX_LAST);
    end else begin
      cnt_n = cnt + 1'b1;
    end
    state_n = !en ? S_IDLE : (int'(cnt_n) < BLANK ? S_BLANK : S_ON);
    // A commit always takes the staged frame as it was before this edge; an
    // update on the same edge overwrites staged and keeps pending set.
    shadow_data_n = (commit && pending) ? staged_data : shadow_data;
    shadow_dp_n   = (commit && pending) ? staged_dp : shadow_dp;
    staged_data_n = update ? data : staged_data;
    staged_dp_n   = update ? dp_in : staged_dp;
    pending_n     = update ? 1'b1 : (commit ? 1'b0 : pending);
    hex_n = (state_n == S_IDLE) ? 4'h0 : shadow_data_n[idx_n*4 +: 4];
    dp_n  = (state_n == S_IDLE) ? 1'b0 : shadow_dp_n[idx_n];
    an_n  = (state_n == S_ON && digit_en[idx_n]) ? (DIGITS'(1) << idx_n) : '0;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= S_IDLE;
      cnt         <= '0;
      idx         <= '0;
      staged_data <= '0;
      staged_dp   <= '0;
      shadow_data <= '0;
      shadow_dp   <= '0;
      pending     <= 1'b0;
      hex         <= 4'h0;
      dp_out      <= 1'b0;
      an          <= '0;
      frame_start <= 1'b0;
      busy        <= 1'b0;
    end else begin
      state       <= state_n;
      cnt         <= cnt_n;
      idx         <= idx_n;
      staged_data <= staged_data_n;
      staged_dp   <= staged_dp_n;
      shadow_data <= shadow_data_n;
      shadow_dp   <= shadow_dp_n;
      pending     <= pending_n;
      hex         <= hex_n;
      dp_out      <= dp_n;
      an          <= an_n;
      frame_start <= commit;
      busy        <= pending_n;
    end
  end
endmodule

// File: tb/tb_seg_scan.sv
// tb_seg_scan: scoreboard bench for seg_scan (DIGITS=4, SCAN_DIV=8, BLANK=2)
module tb_seg_scan;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic en = 1'b0;
  logic update = 1'b0;
  logic [15:0] data = '0;
  logic [3:0] dp_in = '0;
  logic [3:0] digit_en = 4'hf;
  logic [3:0] hex;
  logic dp_out;
  logic [3:0] an;
  logic frame_start;
  logic busy;
  seg_scan #(.DIGITS(4), .SCAN_DIV(8), .BLANK(2)) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .update(update), .data(data),
    .dp_in(dp_in), .digit_en(digit_en), .hex(hex), .dp_out(dp_out),
    .an(an), .frame_start(frame_start), .busy(busy)
  );
  always #5 clk = ~clk;
  typedef struct packed {
    logic [3:0] an;
    logic [3:0] hex;
    logic dp;
    logic fs;
    logic busy;
  } exp_t;
  exp_t sb[$];
  int n_chk = 0;
  int n_fail = 0;
  int mt = -1;
  logic [15:0] m_sd = '0, m_hd = '0;
  logic [3:0] m_sdp = '0, m_hdp = '0;
  logic m_pend = 1'b0;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h at %0t", tag, got, exp, $time);
    end
  endtask
  // Reference: a running count of cycles since activation; position within
  // the 32-cycle frame gives the slot and the in-slot offset directly.
  function automatic exp_t predict();
    exp_t e;
    int p, slot, c;
    logic cm;
    mt = en ? mt + 1 : -1;
    p = (mt < 0) ? 0 : mt % 32;
    slot = p / 8;
    c = p % 8;
    cm = en && p == 0;
    if (cm && m_pend) begin
      m_hd = m_sd;
      m_hdp = m_sdp;
    end
    m_pend = update ? 1'b1 : (cm ? 1'b0 : m_pend);
    if (update) begin
      m_sd = data;
      m_sdp = dp_in;
    end
    e.an = (en && c >= 2 && digit_en[slot]) ? 4'(1 << slot) : 4'h0;
    e.hex = en ? m_hd[slot*4 +: 4] : 4'h0;
    e.dp = en ? m_hdp[slot] : 1'b0;
    e.fs = cm;
    e.busy = m_pend;
    return e;
  endfunction
  task automatic step();
    exp_t e;
    sb.push_back(predict());
    @(posedge clk);
    #1;
    if (sb.size() == 0) begin
      check("sb_empty", 0, 1);
    end else begin
      e = sb.pop_front();
      check("an", 32'(an), 32'(e.an));
      check("hex", 32'(hex), 32'(e.hex));
      check("dp", 32'(dp_out), 32'(e.dp));
      check("frame_start", 32'(frame_start), 32'(e.fs));
      check("busy", 32'(busy), 32'(e.busy));
    end
  endtask
  task automatic run(input int n);
    for (int i = 0; i < n; i++) step();
  endtask
  // Advance until the model sits at frame position pos (i.e. the DUT is in it).
  task automatic run_to(input int pos);
    int k;
    k = 0;
    while (!(mt >= 0 && mt % 32 == pos) && k < 64) begin
      step();
      k++;
    end
    check("run_to_bound", 32'(mt >= 0 && mt % 32 == pos), 1);
  endtask
  task automatic stage(input logic [15:0] d, input logic [3:0] p);
    data = d;
    dp_in = p;
    update = 1'b1;
    step();
    update = 1'b0;
  endtask
  task automatic check_zero(input string tag);
    check({tag, "_an"}, 32'(an), 0);
    check({tag, "_hex"}, 32'(hex), 0);
    check({tag, "_dp"}, 32'(dp_out), 0);
    check({tag, "_fs"}, 32'(frame_start), 0);
    check({tag, "_busy"}, 32'(busy), 0);
  endtask
  initial begin
    #12;
    check_zero("reset");
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    run(20);
    stage(16'h1234, 4'b0001);
    en = 1'b1;
    run(8);
    check("slot0_hex_direct", 32'(hex), 32'h4);
    run(60);
    run_to(20);
    stage(16'hABCD, 4'b0000);
    check("busy_after_update", 32'(busy), 1);
    run_to(0);
    check("commit_hex_d", 32'(hex), 32'hd);
    check("commit_busy_low", 32'(busy), 0);
    run_to(10);
    stage(16'h1111, 4'b1111);
    run_to(31);
    stage(16'h5678, 4'b0010);
    check("wrap_hex_old_staged", 32'(hex), 32'h1);
    check("wrap_busy_held", 32'(busy), 1);
    run(32);
    check("wrap_new_hex", 32'(hex), 32'h8);
    digit_en = 4'b1010;
    run(40);
    digit_en = 4'hf;
    run_to(21);
    en = 1'b0;
    step();
    check("en_drop_an", 32'(an), 0);
    check("en_drop_hex", 32'(hex), 0);
    run(5);
    stage(16'h9abc, 4'b0100);
    en = 1'b1;
    step();
    check("reenable_fs", 32'(frame_start), 1);
    run(45);
    #3;
    rst_n = 1'b0;
    #1;
    check_zero("async_reset");
    mt = -1;
    m_sd = '0;
    m_hd = '0;
    m_sdp = '0;
    m_hdp = '0;
    m_pend = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    run(20);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end
endmodule

// File: doc/seg_scan.md
# seg_scan

Time-multiplexed scan controller for a common-digit-bus seven-segment display. It holds a frame of `DIGITS` hex nibbles plus decimal points and cycles through them one digit slot at a time. It drives one nibble and its decimal point to the hex-to-segment decoder, together with a one-hot digit-select. New display data is staged and committed only at frame boundaries, so a digit pattern never tears mid-frame. Each slot opens with a blanking interval to suppress ghosting between digits.

## Interface
- `DIGITS`, 4: number of digits scanned; legal 2..8.
- `SCAN_DIV`, 1000: clock cycles per digit slot; legal ≥ `BLANK`+2.
- `BLANK`, 4: cycles at slot start with all digit selects off; legal ≥ 0.

- `clk` in 1: single clock, rising edge.
- `rst_n` in 1: asynchronous active-low reset.
- `en` in 1: scan enable; 0 holds controller idle with display dark.
- `update` in 1: single-cycle strobe; stage `data`/`dp_in`.
- `data` in 4*`DIGITS`: digit i nibble = `data[4i+3:4i]`; digit 0 = LSB nibble.
- `dp_in` in `DIGITS`: decimal point per digit.
- `digit_en` in `DIGITS`: live mask; a 0 keeps that digit dark for its slot.
- `hex` out 4: nibble of current slot, to decoder.
- `dp_out` out 1: decimal point of current slot.
- `an` out `DIGITS`: one-hot active-high digit select, or all-zero.
- `frame_start` out 1: one-cycle pulse on first cycle of slot 0.
- `busy` out 1: staged data pending commit.

## Operation
- Registers: prescaler `cnt` (0..`SCAN_DIV`-1), slot index `idx` (0..`DIGITS`-1), `staged` frame, `shadow` (displayed) frame, `pending` flag, state.
- States:
  - IDLE: entered on reset or when `en`=0. In IDLE, `cnt`=0, `idx`=0, `an`=0.
  - BLANK: `cnt` < `BLANK`; `an`=0.
  - ON: `cnt` ≥ `BLANK`; `an` = one-hot(`idx`) if `digit_en[idx]`, else 0.
- In BLANK and ON, `hex`/`dp_out` always show the `shadow` nibble and dp for `idx`. In IDLE, both are 0.
- Slot advance: at `cnt`=`SCAN_DIV`-1, `cnt`→0 and `idx`→`idx`+1, wrapping `DIGITS`-1→0. The state re-enters BLANK, or ON if `BLANK`=0.
- Commit:
  - On entry to slot 0 (wrap or IDLE→active), if `pending` then `shadow`←`staged` and `pending`←0.
  - `frame_start` pulses on that same entry cycle.
- `update`: `staged`←{`data`,`dp_in`}, `pending`←1. Repeated updates before a commit overwrite `staged`; the last one wins.
- `update` in the same cycle as a commit: the commit takes the previous `staged`. The new value lands in `staged` and `pending` stays 1.
- `en` falls at any point: the next edge goes to IDLE with `an`=0. `shadow`, `staged` and `pending` are retained.
- `en` rises: the next edge enters slot 0 at `cnt`=0 (BLANK), commits if pending, and pulses `frame_start`.
- `busy` = `pending`.
- `digit_en` changes take effect on the next edge, even mid-slot.

## Timing
- Reset values: `an`=0, `hex`=0, `dp_out`=0, `frame_start`=0, `busy`=0, `shadow`=0, `staged`=0, `cnt`=0, `idx`=0, state IDLE.
- All outputs are registered. They update on the same edge as `cnt`/`idx` and describe the state just entered.
- `an` never has two bits set. Between two lit digits there are `BLANK` all-zero cycles; with `BLANK`=0 there are none.
- Frame period: `DIGITS`*`SCAN_DIV` cycles.
- `update`→`busy` high: 1 cycle. `busy` low: on the commit edge.
- Worst-case `update`→display latency: one frame plus 1 cycle.
- Reset asserted mid-operation clears everything immediately, asynchronously. The first active slot follows the first edge after release with `en`=1.

## Test plan
- Reset (`DIGITS`=4, `SCAN_DIV`=8, `BLANK`=2 throughout) → all outputs 0. With `en`=0 for 20 cycles, `an` stays 0.
- `update` with `data`=16'h1234, `dp_in`=4'b0001, then `en`=1:
  - `frame_start`=1 on the first active cycle.
  - Cycles 0-1: `an`=0, `hex`=4.
  - Cycles 2-7: `an`=0001, `hex`=4, `dp_out`=1.
  - Next slots show `hex`=3/0010, 2/0100, 1/1000.
  - `frame_start` repeats every 32 cycles.
- `update` `data`=16'hABCD mid-slot 2 → `busy`=1. The display keeps 1234 until the wrap, then `busy`=0 and slot 0 shows `hex`=D.
- `update` coincident with the wrap edge → the old `staged` is displayed, `busy` stays 1, and the new data appears one frame later.
- `digit_en`=4'b1010 → `an` is 0 throughout slots 0 and 2; slots 1 and 3 behave normally.
- `en` dropped in slot 2 at `cnt`=5 → `an`=0 and `hex`=0 next cycle. On re-enable, the scan restarts at slot 0 with `cnt`=0 and `frame_start`=1.
